// File: rtl/flit_packetizer.sv
// flit_packetizer: network-interface transmitter that turns a packet descriptor
// plus a payload word stream into HEAD / BODY / TAIL flits for a router local
// input port. Payload is passed straight through with no buffering. Descriptors
// whose destination lies outside the mesh are dropped: their payload is
// drained and err_o pulses for one cycle.
module flit_packetizer #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3,
  parameter int X_WIDTH    = 2,
  parameter int Y_WIDTH    = 2,
  parameter int PKT_WIDTH  = 8,
  parameter int NOC_ROWS   = 2,
  parameter int NOC_COLS   = 2,
  localparam int VC_WIDTH  = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [X_WIDTH-1:0]    pkt_x_i,
  input  logic [Y_WIDTH-1:0]    pkt_y_i,
  input  logic [VC_WIDTH-1:0]   pkt_vc_i,
  input  logic [PKT_WIDTH-1:0]  pkt_len_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [FLIT_WIDTH-3:0] data_i,
  output logic                  flit_valid_o,
  input  logic                  flit_ready_i,
  output logic [VC_WIDTH-1:0]   flit_vc_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  err_o
);

  // Zero bits that fill the head flit below the routing fields.
  localparam int HEAD_PAD = FLIT_WIDTH - 2 - X_WIDTH - Y_WIDTH - PKT_WIDTH;

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAYLOAD,
    DRAIN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [X_WIDTH-1:0]    x_q;
  logic [Y_WIDTH-1:0]    y_q;
  logic [VC_WIDTH-1:0]   vc_q;
  logic [PKT_WIDTH-1:0]  rem_q;
  logic [PKT_WIDTH-1:0]  rem_d;
  logic                  err_q;
  logic                  err_d;
  logic                  latch_desc;
  logic                  bad_dest;
  logic                  word_taken;
  logic [FLIT_WIDTH-1:0] head_flit;

  // A destination outside the mesh cannot be routed, so the packet is dropped.
  assign bad_dest = (int'(pkt_x_i) >= NOC_ROWS) || (int'(pkt_y_i) >= NOC_COLS);

  // rem still holds the full payload length while the head is on the wire.
  assign head_flit = {TYPE_HEAD, x_q, y_q, rem_q, {HEAD_PAD{1'b0}}};

  assign flit_vc_o = vc_q;
  assign err_o     = err_q;

  // State register; reset abandons any partial packet without emitting a tail.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor fields, remaining-word count and the one-cycle drop flag.
  always_ff @(posedge clk) begin
    if (arst) begin
      x_q   <= '0;
      y_q   <= '0;
      vc_q  <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      err_q <= err_d;
      if (latch_desc) begin
        x_q  <= pkt_x_i;
        y_q  <= pkt_y_i;
        vc_q <= pkt_vc_i;
      end
    end
  end

  // Next-state and handshake logic; rem is only decremented when non-zero.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    err_d        = 1'b0;
    latch_desc   = 1'b0;
    word_taken   = 1'b0;
    pkt_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    flit_valid_o = 1'b0;
    flit_o       = '0;
    case (state_q)
      IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) begin
          latch_desc = 1'b1;
          rem_d      = pkt_len_i;
          if (bad_dest) begin
            err_d   = 1'b1;
            state_d = (pkt_len_i != '0) ? DRAIN : IDLE;
          end else begin
            state_d = HEAD;
          end
        end
      end
      HEAD: begin
        flit_valid_o = 1'b1;
        flit_o       = head_flit;
        if (flit_ready_i) begin
          state_d = (rem_q == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        flit_valid_o = data_valid_i;
        data_ready_o = flit_ready_i;
        flit_o       = {(rem_q == PKT_WIDTH'(1)) ? TYPE_TAIL : TYPE_BODY, data_i};
        word_taken   = data_valid_i && flit_ready_i;
      end
      DRAIN: begin
        data_ready_o = 1'b1;
        word_taken   = data_valid_i;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (word_taken && (rem_q != '0)) begin
      rem_d = rem_q - PKT_WIDTH'(1);
      if (rem_q == PKT_WIDTH'(1)) begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: table of packet descriptors driven through the
// packetizer, with expected flits queued at stimulus time and popped as the
// router side accepts them; reset and back-to-back corners are hand-written.
module tb_flit_packetizer;

  localparam int FW = 34;
  localparam int DW = FW - 2;
  localparam int VW = 2;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          pkt_valid_i;
  logic          pkt_ready_o;
  logic [XW-1:0] pkt_x_i;
  logic [YW-1:0] pkt_y_i;
  logic [VW-1:0] pkt_vc_i;
  logic [PW-1:0] pkt_len_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic [DW-1:0] data_i;
  logic          flit_valid_o;
  logic          flit_ready_i;
  logic [VW-1:0] flit_vc_o;
  logic [FW-1:0] flit_o;
  logic          err_o;

  flit_packetizer dut (
    .clk         (clk),
    .arst        (arst),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .pkt_x_i     (pkt_x_i),
    .pkt_y_i     (pkt_y_i),
    .pkt_vc_i    (pkt_vc_i),
    .pkt_len_i   (pkt_len_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .data_i      (data_i),
    .flit_valid_o(flit_valid_o),
    .flit_ready_i(flit_ready_i),
    .flit_vc_o   (flit_vc_o),
    .flit_o      (flit_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [VW-1:0] vc;
    logic [PW-1:0] len;
    bit            randReady;
    bit            stall;
    bit            hold;
    bit            expErr;
    int            expFlits;
  } vec_t;

  typedef struct {
    logic [FW-1:0] flit;
    logic [VW-1:0] vc;
  } sb_t;

  sb_t           sbq[$];
  int            hsCycle[$];
  vec_t          tbl[10];
  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            flitCount = 0;
  int            dataTaken = 0;
  int            errPulses = 0;
  int            acceptCycle = 0;
  bit            prevStall = 1'b0;
  logic [FW-1:0] prevFlit = '0;
  logic [VW-1:0] prevVc = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Cycle counter used to measure flit spacing and head latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Router-side monitor: pops the scoreboard on every accepted flit and checks
  // that a stalled flit is held unchanged until it is taken.
  always @(negedge clk) begin
    sb_t e;
    if (arst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", flit_valid_o, 1'b1);
        checkOutput("stall_flit", flit_o, prevFlit);
        checkOutput("stall_vc", flit_vc_o, prevVc);
      end
      prevStall = flit_valid_o && !flit_ready_i;
      prevFlit  = flit_o;
      prevVc    = flit_vc_o;
      if (flit_valid_o && flit_ready_i) begin
        flitCount++;
        hsCycle.push_back(cycle);
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_flit: got flit=%h vc=%0d, expected no flit", flit_o, flit_vc_o);
        end else begin
          e = sbq.pop_front();
          if (flit_o !== e.flit || flit_vc_o !== e.vc) begin
            errors++;
            $display("[TB] FAIL flit_check: got flit=%h vc=%0d, expected flit=%h vc=%0d",
                     flit_o, flit_vc_o, e.flit, e.vc);
          end
        end
      end
      if (data_valid_i && data_ready_o) dataTaken++;
      if (err_o) errPulses++;
    end
  end

  // Drives one descriptor and its payload, queueing the expected flits first.
  task automatic applyStimulus(input vec_t v);
    logic [DW-1:0] words[$];
    sb_t e;
    int idx;
    int budget;
    int stallLeft;
    int flits0;
    int taken0;
    bit headStallDone;
    bit tailStallDone;
    for (int k = 0; k < int'(v.len); k++) words.push_back(DW'($urandom()));
    if (!v.expErr) begin
      e.flit = {2'b00, v.x, v.y, v.len, 20'd0};
      e.vc   = v.vc;
      sbq.push_back(e);
      for (int k = 0; k < int'(v.len); k++) begin
        e.flit = {(k == int'(v.len) - 1) ? 2'b10 : 2'b01, words[k]};
        sbq.push_back(e);
      end
    end
    flits0       = flitCount;
    taken0       = dataTaken;
    pkt_x_i      = v.x;
    pkt_y_i      = v.y;
    pkt_vc_i     = v.vc;
    pkt_len_i    = v.len;
    pkt_valid_i  = 1'b1;
    flit_ready_i = 1'b1;
    data_valid_i = 1'b0;
    budget = 20;
    while (!pkt_ready_o && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checkOutput("desc_ready", pkt_ready_o, 1'b1);
    acceptCycle = cycle;
    @(posedge clk); #1;
    if (!v.hold) pkt_valid_i = 1'b0;
    checkOutput("err_pulse", err_o, v.expErr);
    idx = 0;
    budget = 8 * int'(v.len) + 40;
    stallLeft = 0;
    headStallDone = 1'b0;
    tailStallDone = 1'b0;
    while ((idx < int'(v.len) || sbq.size() != 0) && budget > 0) begin
      if (!v.expErr && sbq.size() == int'(v.len) + 1)
        checkOutput("holdoff", data_ready_o, 1'b0);
      if (v.stall && !v.expErr) begin
        if (!headStallDone && sbq.size() == int'(v.len) + 1) begin
          stallLeft = 3;
          headStallDone = 1'b1;
        end
        if (!tailStallDone && sbq.size() == 1 && idx == int'(v.len) - 1) begin
          stallLeft = 3;
          tailStallDone = 1'b1;
        end
      end
      if (idx < int'(v.len)) begin
        data_valid_i = 1'b1;
        data_i       = words[idx];
      end else begin
        data_valid_i = 1'b0;
        data_i       = '0;
      end
      if (stallLeft > 0) begin
        flit_ready_i = 1'b0;
        stallLeft--;
      end else begin
        flit_ready_i = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (data_valid_i && data_ready_o) idx++;
      @(posedge clk); #1;
      budget--;
      checkOutput("err_idle", err_o, 1'b0);
    end
    checkOutput("packet_done", (idx < int'(v.len) || sbq.size() != 0) ? 1'b0 : 1'b1, 1'b1);
    sbq.delete();
    data_valid_i = 1'b0;
    flit_ready_i = 1'b1;
    checkOutput("ready_back", pkt_ready_o, 1'b1);
    checkOutput("flit_count", 64'(flitCount - flits0), 64'(v.expFlits));
    checkOutput("words_taken", 64'(dataTaken - taken0), 64'(v.len));
  endtask

  // Main sequence: reset, descriptor table, mid-packet reset, final tallies.
  initial begin
    sb_t e;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    //            x     y     vc    len     rand  stall hold  err   flits
    tbl[0] = '{2'd1, 2'd0, 2'd2, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 4};
    tbl[1] = '{2'd0, 2'd1, 2'd0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{2'd1, 2'd1, 2'd1, 8'd2,   1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[3] = '{2'd2, 2'd0, 2'd1, 8'd2,   1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{2'd0, 2'd2, 2'd0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[5] = '{2'd3, 2'd3, 2'd2, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{2'd1, 2'd1, 2'd0, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 256};
    tbl[7] = '{2'd0, 2'd0, 2'd1, 8'd5,   1'b1, 1'b0, 1'b0, 1'b0, 6};
    tbl[8] = '{2'd1, 2'd0, 2'd1, 8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[9] = '{2'd0, 2'd1, 2'd2, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 2};

    arst         = 1'b1;
    pkt_valid_i  = 1'b0;
    pkt_x_i      = '0;
    pkt_y_i      = '0;
    pkt_vc_i     = '0;
    pkt_len_i    = '0;
    data_valid_i = 1'b0;
    data_i       = '0;
    flit_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pkt_ready", pkt_ready_o, 1'b1);
    checkOutput("rst_flit_valid", flit_valid_o, 1'b0);
    checkOutput("rst_data_ready", data_ready_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_flit", flit_o, '0);
    checkOutput("rst_vc", flit_vc_o, '0);
    arst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (i == 0 || !tbl[i-1].hold) hsCycle.delete();
      applyStimulus(tbl[i]);
      if (i == 0) begin
        checkOutput("head_latency", 64'(hsCycle[0]), 64'(acceptCycle + 1));
        for (int k = 1; k < 4; k++)
          checkOutput("consecutive", 64'(hsCycle[k] - hsCycle[k-1]), 64'd1);
      end
      if (i == 9) begin
        checkOutput("b2b_gap0", 64'(hsCycle[1] - hsCycle[0]), 64'd1);
        checkOutput("b2b_gap1", 64'(hsCycle[2] - hsCycle[1]), 64'd2);
        checkOutput("b2b_gap2", 64'(hsCycle[3] - hsCycle[2]), 64'd1);
      end
    end

    // Reset mid-packet: head and first body go out, then the packet is abandoned.
    w0 = DW'($urandom());
    w1 = DW'($urandom());
    pkt_x_i      = 2'd1;
    pkt_y_i      = 2'd1;
    pkt_vc_i     = 2'd1;
    pkt_len_i    = 8'd4;
    pkt_valid_i  = 1'b1;
    flit_ready_i = 1'b1;
    checkOutput("t5_desc_ready", pkt_ready_o, 1'b1);
    e.vc   = 2'd1;
    e.flit = {2'b00, 2'd1, 2'd1, 8'd4, 20'd0};
    sbq.push_back(e);
    e.flit = {2'b01, w0};
    sbq.push_back(e);
    @(posedge clk); #1;
    pkt_valid_i  = 1'b0;
    data_valid_i = 1'b1;
    data_i       = w0;
    checkOutput("t5_holdoff", data_ready_o, 1'b0);
    @(posedge clk); #1;
    checkOutput("t5_body_ready", data_ready_o, 1'b1);
    @(posedge clk); #1;
    data_i = w1;
    arst   = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_pkt_ready", pkt_ready_o, 1'b1);
    checkOutput("t5_flit_valid", flit_valid_o, 1'b0);
    checkOutput("t5_data_ready", data_ready_o, 1'b0);
    checkOutput("t5_err", err_o, 1'b0);
    checkOutput("t5_flit", flit_o, '0);
    checkOutput("t5_vc", flit_vc_o, '0);
    checkOutput("t5_sb_empty", 64'(sbq.size()), 64'd0);
    arst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("t5_no_tail", flit_valid_o, 1'b0);
      checkOutput("t5_idle_hold", data_ready_o, 1'b0);
    end
    data_valid_i = 1'b0;
    applyStimulus('{2'd0, 2'd0, 2'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3});

    checkOutput("err_pulses", 64'(errPulses), 64'd3);
    checkOutput("sb_final_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test by 500000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
